// File: rtl/arbitro_memoria_dados.sv
// ============================================================================
// Module   : arbitro_memoria_dados
// Purpose  : Two-requester arbiter and access sequencer for the single-port
//            data memory (synchronous write, combinational read). Port 0 is
//            the CPU load/store stage, port 1 the I/O/DMA engine. Accesses are
//            serialised, out-of-range addresses never reach the array, and
//            each port gets a one-cycle completion pulse.
// Ports    : clock, reset_n            - clock (rising edge), async active-low reset
//            req/we/end/dado_esc 0,1   - per-port request, write enable, address, write data
//            ack/dado_lido/erro 0,1    - per-port completion, read data, range error
//            mem_endereco/memWrite/dado_Escrito - drive the memory (zero outside ACESSO)
//            mem_dado_Lido             - combinational read data from the memory
//            ocupado                   - high whenever the sequencer is not idle
// Options  : ARB_CPU_PRIORIDADE_FIXA_EN - when defined, port 0 always wins a
//            simultaneous request; otherwise round-robin between the ports.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module arbitro_memoria_dados #(
  parameter int LARGURA_DADO = 32,
  parameter int LARGURA_END  = 26,
  parameter int PROFUNDIDADE = 51
) (
  input  logic                    clock,
  input  logic                    reset_n,

  input  logic                    req0,
  input  logic                    we0,
  input  logic [LARGURA_END-1:0]  end0,
  input  logic [LARGURA_DADO-1:0] dado_esc0,
  output logic                    ack0,
  output logic [LARGURA_DADO-1:0] dado_lido0,
  output logic                    erro0,

  input  logic                    req1,
  input  logic                    we1,
  input  logic [LARGURA_END-1:0]  end1,
  input  logic [LARGURA_DADO-1:0] dado_esc1,
  output logic                    ack1,
  output logic [LARGURA_DADO-1:0] dado_lido1,
  output logic                    erro1,

  output logic [LARGURA_END-1:0]  mem_endereco,
  output logic                    mem_memWrite,
  output logic [LARGURA_DADO-1:0] mem_dado_Escrito,
  input  logic [LARGURA_DADO-1:0] mem_dado_Lido,

  output logic                    ocupado
);

  // Range limit at full address width so the comparison is unsigned and exact.
  localparam logic [LARGURA_END-1:0] c_limite = LARGURA_END'(PROFUNDIDADE);

  typedef enum logic [1:0] {
    OCIOSO  = 2'd0,
    ACESSO  = 2'd1,
    CONCLUI = 2'd2
  } estado_t;

  estado_t estado;
  logic    sel;
`ifndef ARB_CPU_PRIORIDADE_FIXA_EN
  logic    prioridade;
`endif

  logic                    we_sel;
  logic [LARGURA_END-1:0]  end_sel;
  logic [LARGURA_DADO-1:0] dado_esc_sel;
  logic                    fora_faixa;
  logic                    em_acesso;

  assign we_sel       = sel ? we1       : we0;
  assign end_sel      = sel ? end1      : end0;
  assign dado_esc_sel = sel ? dado_esc1 : dado_esc0;
  assign fora_faixa   = (end_sel >= c_limite);

  // The state register resets asynchronously, so the memory lines fall to
  // zero the moment reset_n drops, even in the middle of an access.
  assign em_acesso        = (estado == ACESSO);
  assign mem_endereco     = em_acesso ? end_sel      : '0;
  assign mem_dado_Escrito = em_acesso ? dado_esc_sel : '0;
  assign mem_memWrite     = em_acesso & we_sel & ~fora_faixa;
  assign ocupado          = (estado != OCIOSO);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      estado     <= OCIOSO;
      sel        <= 1'b0;
`ifndef ARB_CPU_PRIORIDADE_FIXA_EN
      prioridade <= 1'b0;
`endif
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      erro0      <= 1'b0;
      erro1      <= 1'b0;
      dado_lido0 <= '0;
      dado_lido1 <= '0;
    end else begin
      case (estado)
        OCIOSO: begin
          if (req0 && req1) begin
`ifdef ARB_CPU_PRIORIDADE_FIXA_EN
            sel        <= 1'b0;
`else
            // Winner takes the grant, the other port is favoured next time.
            sel        <= prioridade;
            prioridade <= ~prioridade;
`endif
            estado     <= ACESSO;
          end else if (req0) begin
            sel    <= 1'b0;
            estado <= ACESSO;
          end else if (req1) begin
            sel    <= 1'b1;
            estado <= ACESSO;
          end
        end

        ACESSO: begin
          // Only the selected port's result registers change; a write leaves
          // the read-data register holding its previous value.
          if (!sel) begin
            ack0  <= 1'b1;
            erro0 <= fora_faixa;
            if (!we_sel) begin
              dado_lido0 <= fora_faixa ? '0 : mem_dado_Lido;
            end
          end else begin
            ack1  <= 1'b1;
            erro1 <= fora_faixa;
            if (!we_sel) begin
              dado_lido1 <= fora_faixa ? '0 : mem_dado_Lido;
            end
          end
          estado <= CONCLUI;
        end

        CONCLUI: begin
          // Requests are not sampled here, giving the requester a cycle to
          // withdraw req after seeing its ack.
          ack0   <= 1'b0;
          ack1   <= 1'b0;
          erro0  <= 1'b0;
          erro1  <= 1'b0;
          estado <= OCIOSO;
        end

        default: begin
          estado <= OCIOSO;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_arbitro_memoria_dados.sv
// ============================================================================
// Module   : tb_arbitro_memoria_dados
// Purpose  : Self-checking bench for arbitro_memoria_dados with a behavioural
//            memory device and a transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_arbitro_memoria_dados;

  localparam int LD   = 32;
  localparam int LE   = 26;
  localparam int PROF = 51;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          req0, we0, req1, we1;
  logic [LE-1:0] end0, end1;
  logic [LD-1:0] dado_esc0, dado_esc1;
  logic          ack0, ack1, erro0, erro1;
  logic [LD-1:0] dado_lido0, dado_lido1;
  logic [LE-1:0] mem_endereco;
  logic          mem_memWrite;
  logic [LD-1:0] mem_dado_Escrito, mem_dado_Lido;
  logic          ocupado;

  always #5 clock = ~clock;

  arbitro_memoria_dados #(
    .LARGURA_DADO(LD), .LARGURA_END(LE), .PROFUNDIDADE(PROF)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .req0(req0), .we0(we0), .end0(end0), .dado_esc0(dado_esc0),
    .ack0(ack0), .dado_lido0(dado_lido0), .erro0(erro0),
    .req1(req1), .we1(we1), .end1(end1), .dado_esc1(dado_esc1),
    .ack1(ack1), .dado_lido1(dado_lido1), .erro1(erro1),
    .mem_endereco(mem_endereco), .mem_memWrite(mem_memWrite),
    .mem_dado_Escrito(mem_dado_Escrito), .mem_dado_Lido(mem_dado_Lido),
    .ocupado(ocupado)
  );

  // Memory device: sync write, combinational read; junk beyond the valid range.
  logic [LD-1:0] mem_arr [64];
  always @(posedge clock) if (mem_memWrite) mem_arr[mem_endereco[5:0]] <= mem_dado_Escrito;
  assign mem_dado_Lido = (mem_endereco < LE'(PROF)) ? mem_arr[mem_endereco[5:0]] : 32'hA5A5_5A5A;

  // Reference model state
  logic [LD-1:0] ref_mem [PROF];
  logic [LD-1:0] lido_m [2];
  bit            pri_m;
  int            errors = 0;
  int            checks = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input int p, input bit r, input bit w, input logic [LE-1:0] a, input logic [LD-1:0] d);
    if (p == 0) begin req0 = r; we0 = w; end0 = a; dado_esc0 = d; end
    else        begin req1 = r; we1 = w; end1 = a; dado_esc1 = d; end
  endtask

  // Winner of a simultaneous request, and the fairness bookkeeping that goes with it.
  task automatic arbitrate(output int win);
`ifdef ARB_CPU_PRIORIDADE_FIXA_EN
    win = 0;
`else
    win   = pri_m ? 1 : 0;
    pri_m = (win == 0);
`endif
  endtask

  // Effect of one completed access on memory and on the port's read register.
  task automatic model_access(input int p, input bit w, input logic [LE-1:0] a,
                              input logic [LD-1:0] d, output bit e);
    e = (a >= LE'(PROF));
    if (w) begin
      if (!e) ref_mem[int'(a)] = d;
    end else begin
      lido_m[p] = e ? '0 : ref_mem[int'(a)];
    end
  endtask

  function automatic logic [LE-1:0] rand_addr();
    if ($urandom_range(0, 4) != 0) return LE'($urandom_range(0, PROF-1));
    case ($urandom_range(0, 3))
      0:       return LE'(PROF);
      1:       return LE'(PROF + 1);
      2:       return {LE{1'b1}};
      default: return LE'($urandom) | LE'(64);
    endcase
  endfunction

  // One arbitration round: raise the selected requests, watch 7 cycles and
  // compare every output against the model's timeline (winner ack at cycle 2,
  // loser ack at cycle 5). Each port drops req as soon as it sees its ack.
  task automatic round(input bit r0, input bit r1, input bit w0, input bit w1,
                       input logic [LE-1:0] a0, input logic [LE-1:0] a1,
                       input logic [LD-1:0] d0, input logic [LD-1:0] d1);
    int            ackc [2];
    bit            e_m  [2];
    logic [LD-1:0] old_l[2];
    logic [LD-1:0] new_l[2];
    bit            ww   [2];
    logic [LE-1:0] aa   [2];
    logic [LD-1:0] dd   [2];
    int            win, acc;
    bit            busy;
    ww[0] = w0; ww[1] = w1; aa[0] = a0; aa[1] = a1; dd[0] = d0; dd[1] = d1;
    ackc[0] = 0; ackc[1] = 0; e_m[0] = 0; e_m[1] = 0;
    old_l[0] = lido_m[0]; old_l[1] = lido_m[1];
    if (!r0 && !r1) return;
    if (r0 && r1) arbitrate(win);
    else          win = r1 ? 1 : 0;
    ackc[win] = 2;
    model_access(win, ww[win], aa[win], dd[win], e_m[win]);
    if (r0 && r1) begin
      ackc[1-win] = 5;
      model_access(1-win, ww[1-win], aa[1-win], dd[1-win], e_m[1-win]);
    end
    new_l[0] = lido_m[0]; new_l[1] = lido_m[1];

    @(negedge clock);
    drive(0, r0, w0, a0, d0);
    drive(1, r1, w1, a1, d1);
    for (int c = 1; c <= 7; c++) begin
      @(negedge clock);
      acc = -1;
      for (int p = 0; p < 2; p++) if (ackc[p] == c + 1) acc = p;
      busy = (acc >= 0) || (ackc[0] == c) || (ackc[1] == c);
      check_val("ack0", ack0, ackc[0] == c);
      check_val("ack1", ack1, ackc[1] == c);
      check_val("ocupado", ocupado, busy);
      if (acc >= 0) begin
        check_val("mem_we",  mem_memWrite, ww[acc] && (aa[acc] < LE'(PROF)));
        check_val("mem_end", mem_endereco, aa[acc]);
        check_val("mem_wd",  mem_dado_Escrito, dd[acc]);
      end else begin
        check_val("mem_we_idle",  mem_memWrite, 0);
        check_val("mem_end_idle", mem_endereco, 0);
        check_val("mem_wd_idle",  mem_dado_Escrito, 0);
      end
      check_val("erro0", erro0, (ackc[0] == c) ? e_m[0] : 1'b0);
      check_val("erro1", erro1, (ackc[1] == c) ? e_m[1] : 1'b0);
      check_val("lido0", dado_lido0, (ackc[0] != 0 && c >= ackc[0]) ? new_l[0] : old_l[0]);
      check_val("lido1", dado_lido1, (ackc[1] != 0 && c >= ackc[1]) ? new_l[1] : old_l[1]);
      if (ackc[0] == c) req0 = 1'b0;
      if (ackc[1] == c) req1 = 1'b0;
    end
  endtask

  // Both ports keep req high across acks: six reads, grant order from the model.
  task automatic continuous_reads();
    logic [LE-1:0] a0, a1;
    int            win, nacks;
    bit            dummy;
    a0 = LE'($urandom_range(0, PROF-1));
    a1 = LE'($urandom_range(0, PROF-1));
    nacks = 0;
    @(negedge clock);
    drive(0, 1, 0, a0, '0);
    drive(1, 1, 0, a1, '0);
    for (int c = 1; c <= 18; c++) begin
      @(negedge clock);
      if (c >= 2 && c <= 17 && ((c - 2) % 3) == 0) begin
        arbitrate(win);
        model_access(win, 1'b0, (win == 0) ? a0 : a1, '0, dummy);
        check_val("order_ack0", ack0, win == 0);
        check_val("order_ack1", ack1, win == 1);
        check_val((win == 0) ? "cont_lido0" : "cont_lido1",
                  (win == 0) ? dado_lido0 : dado_lido1, lido_m[win]);
      end else begin
        check_val("cont_ack_gap", {ack1, ack0}, 2'b00);
      end
      if (ack0 || ack1) nacks++;
      if (c == 17) begin req0 = 1'b0; req1 = 1'b0; end
    end
    check_val("cont_nacks", nacks, 6);
  endtask

  // Reset pulse landing in the ACESSO cycle of a port 0 write to word 7.
  task automatic reset_during_write();
    @(negedge clock);
    drive(0, 1, 1, LE'(7), 32'hCAFE_F00D);
    @(negedge clock);
    check_val("rst_pre_we", mem_memWrite, 1);
    #1 reset_n = 1'b0;
    #1;
    check_val("rst_we_drop", mem_memWrite, 0);
    check_val("rst_end_drop", mem_endereco, 0);
    check_val("rst_ocupado", ocupado, 0);
    check_val("rst_ack0", ack0, 0);
    req0 = 1'b0;
    pri_m = 1'b0;
    lido_m[0] = '0; lido_m[1] = '0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      check_val("rst_no_ack0", ack0, 0);
      check_val("rst_idle", ocupado, 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int mode;
    reset_n = 1'b1;
    drive(0, 0, 0, '0, '0);
    drive(1, 0, 0, '0, '0);
    pri_m = 1'b0;
    lido_m[0] = '0; lido_m[1] = '0;
    for (int i = 0; i < 64; i++) begin
      mem_arr[i] = $urandom;
      if (i < PROF) ref_mem[i] = mem_arr[i];
    end
    #2 reset_n = 1'b0;
    #1;
    check_val("reset_ack", {ack1, ack0}, 0);
    check_val("reset_erro", {erro1, erro0}, 0);
    check_val("reset_lido0", dado_lido0, 0);
    check_val("reset_lido1", dado_lido1, 0);
    check_val("reset_ocupado", ocupado, 0);
    check_val("reset_mem", {mem_memWrite, mem_endereco, mem_dado_Escrito}, 0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;

    // Simultaneous requests straight out of reset: port 0 first, port 1 three cycles later.
    round(1, 1, 0, 0, LE'(10), LE'(20), '0, '0);
    // Write then read back word 5 on port 0.
    round(1, 0, 1, 0, LE'(5), '0, 32'hDEAD_BEEF, '0);
    round(1, 0, 0, 0, LE'(5), '0, '0, '0);
    // Out-of-range accesses on port 1.
    round(0, 1, 0, 1, '0, LE'(51), '0, 32'h0000_1234);
    round(0, 1, 0, 0, '0, {LE{1'b1}}, '0, '0);
    // A write after a read leaves the port's read register alone.
    round(1, 0, 0, 0, LE'(3), '0, '0, '0);
    round(1, 0, 1, 0, LE'(9), '0, 32'h0BAD_F00D, '0);

    continuous_reads();
    reset_during_write();
    round(1, 0, 0, 0, LE'(7), '0, '0, '0);

    for (int i = 0; i < 40; i++) begin
      mode = $urandom_range(0, 2);
      round(mode != 1, mode != 0, 1'($urandom), 1'($urandom),
            rand_addr(), rand_addr(), $urandom, $urandom);
    end

    // Full sweep: no stray or lost writes anywhere in the array.
    for (int a = 0; a < PROF; a++) round(0, 1, 0, 0, '0, LE'(a), '0, '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/arbitro_memoria_dados.md
Name: arbitro_memoria_dados

Overview:
- Two-requester arbiter and access sequencer for the single-port data memory (sync write, combinational read).
- Port 0 is the CPU load/store stage. Port 1 is the I/O/DMA engine.
- Serialises accesses, drives the memory address/write/data lines, captures read data, returns a per-port ack.
- Rejects out-of-range addresses before they reach the memory array.

Parameters:
- LARGURA_DADO, 32, data width.
- LARGURA_END, 26, address width.
- PROFUNDIDADE, 51, number of valid memory words; valid addresses are 0..PROFUNDIDADE-1.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req0  in  1  port 0 request; held with we0/end0/dado_esc0 stable until ack0.
- we0  in  1  port 0: 1=write, 0=read.
- end0  in  LARGURA_END  port 0 word address.
- dado_esc0  in  LARGURA_DADO  port 0 write data.
- ack0  out  1  port 0 one-cycle completion pulse.
- dado_lido0  out  LARGURA_DADO  port 0 read data; valid while ack0=1, held until the next port 0 ack.
- erro0  out  1  port 0 out-of-range flag; valid with ack0.
- req1, we1, end1, dado_esc1, ack1, dado_lido1, erro1  same as port 0, for port 1.
- mem_endereco  out  LARGURA_END  to memory address.
- mem_memWrite  out  1  to memory write enable.
- mem_dado_Escrito  out  LARGURA_DADO  to memory write data.
- mem_dado_Lido  in  LARGURA_DADO  from memory read data.
- ocupado  out  1  high when state is not OCIOSO.

Behaviour:
- Reset (async, reset_n=0):
  - state=OCIOSO, sel=0, prioridade=0 (port 0 favoured).
  - ack0/1=0, erro0/1=0, dado_lido0/1=0, ocupado=0.
  - mem_memWrite, mem_endereco and mem_dado_Escrito are 0 immediately, without waiting for a clock edge.
- FSM states OCIOSO -> ACESSO -> CONCLUI -> OCIOSO.
- OCIOSO:
  - No request: stay.
  - One request: sel=that port.
  - Both requests: sel=prioridade, and prioridade is set to the other port.
  - Any grant: go to ACESSO. A single request does not change prioridade.
- ACESSO (exactly 1 cycle):
  - mem_endereco=end_sel and mem_dado_Escrito=dado_esc_sel, combinational from sel.
  - mem_memWrite=we_sel AND (end_sel < PROFUNDIDADE); the write lands on the closing edge.
  - On the closing edge:
    - Read: dado_lido_sel <= mem_dado_Lido. Out-of-range read: dado_lido_sel <= 0.
    - erro_sel <= (end_sel >= PROFUNDIDADE); the comparison uses full LARGURA_END width, unsigned.
    - ack_sel <= 1.
  - Go to CONCLUI.
- CONCLUI (1 cycle):
  - ack_sel=1 and erro_sel as captured; mem_* outputs are 0.
  - Requests are ignored here, so a requester has one cycle to drop req after ack.
  - Next edge: ack and erro clear, go to OCIOSO.
- Outside ACESSO, mem_* outputs are all 0.
- Timing:
  - Latency from req sampled in OCIOSO to ack = 2 cycles.
  - Back-to-back throughput = 1 access per 3 cycles.
- Write-data semantics: dado_lido on a write ack is unchanged (keeps the previous value).
- Non-selected port: its ack, erro and dado_lido are untouched.
- Request behaviour:
  - req dropped before ack: the access still completes, since the grant is committed.
  - req held past CONCLUI: treated as a new request in OCIOSO.
- Reset asserted during ACESSO: mem_memWrite drops immediately, no write occurs, no ack is issued.

Optional Feature:
- Macro ARB_CPU_PRIORIDADE_FIXA_EN.
- Defined: port 0 always wins a simultaneous request; prioridade is unused and held at 0. Port 1 can be starved; this is accepted.
- Undefined: round-robin as described in Behaviour.

Test Plan:
- Port 0 write end0=5, dado_esc0=0xDEADBEEF, then read end0=5 -> mem_memWrite=1 only in the ACESSO cycle; read ack0 2 cycles after req with dado_lido0=0xDEADBEEF, erro0=0.
- req0 and req1 both raised from reset, held until ack -> ack0 first; ack1 3 cycles later; ack1 never overlaps ack0.
- req0 and req1 continuously re-asserted after each ack, 6 accesses -> grant order 0,1,0,1,0,1. With ARB_CPU_PRIORIDADE_FIXA_EN defined -> order 0,0,0,...
- Port 1 write end1=51, dado_esc1=0x1234 -> mem_memWrite stays 0; ack1=1 with erro1=1; a later read of addresses 0..50 shows no change. Read end1=0x3FFFFFF -> dado_lido1=0, erro1=1.
- reset_n pulsed low during ACESSO of a port 0 write to end0=7 -> mem_memWrite falls in the same cycle; word 7 unchanged; ack0 never asserts; ocupado=0.
- Port 0 read end0=3 followed by a port 0 write -> after the write ack, dado_lido0 still holds the word-3 value.
